audio_capture_fsm: RTL
======================

// Module: audio_capture_fsm
// PURPOSE
//  Record-side counterpart of the flash playback path: pulls ADC samples from audio_codec
//  (read_ready/read/readdata_*) once per sampling tick and mixes L/R to signed 16-bit mono.
//  Writes each sample to message RAM and emits a 1-cycle sample_valid to the u-law compressor.
//  Runs on the 50 MHz system clock; sample_tick is the edge_detect_gate output of the 48 kHz divider.
// PARAMETERS
//  CODEC_W   24     width of readdata_left/right (signed)
//  SAMPLE_W  16     output sample width
//  ADDR_W    15     RAM address width; depth = 2**ADDR_W words
//  WRAP      0      0: stop when RAM full; 1: circular overwrite
//  READY_TO  255    max clk cycles to wait for read_ready after a tick before abandoning the sample
// PORTS
//  clk             in   1         50 MHz system clock
//  reset           in   1         synchronous, active-high
//  sample_tick     in   1         1-cycle pulse per sample period
//  start           in   1         level; 1 = recording enabled (SW[1])
//  pause           in   1         level; 1 = hold, no new reads (SW[0])
//  read_ready      in   1         codec has a fresh L/R pair
//  readdata_left   in   CODEC_W   codec left sample
//  readdata_right  in   CODEC_W   codec right sample
//  read            out  1         1-cycle consume strobe to codec
//  ram_wraddress   out  ADDR_W    RAM write address
//  ram_data        out  SAMPLE_W  RAM write data
//  ram_wren        out  1         RAM write enable, 1 cycle
//  sample_out      out  SAMPLE_W  mono sample to compressor (held until next sample)
//  sample_valid    out  1         1-cycle strobe, same cycle as ram_wren
//  full            out  1         RAM full (WRAP=0 only; stays 0 when WRAP=1)
//  overrun_cnt     out  8         saturating count of dropped samples
// BEHAVIOUR
//  Reset: every output 0. FSM -> IDLE. Address = 0.
//  States and transitions:
//   IDLE -> ARMED when start=1.
//   ARMED -> WAIT_RDY on sample_tick when pause=0 and full=0. The tick is ignored while pause=1.
//   WAIT_RDY -> READ when read_ready=1.
//   WAIT_RDY: a timeout of READY_TO cycles increments overrun_cnt and returns to ARMED.
//   READ: read=1 for exactly one cycle. The L/R pair is latched in the same cycle. -> WRITE.
//   WRITE: ram_wren=1 and sample_valid=1 for one cycle; ram_wraddress = current address.
//    Address is incremented after the write. -> ARMED.
//  Latency: from a tick with read_ready already high, read is asserted at tick+2 and
//   ram_wren/sample_valid at tick+3.
//  Mix: sum = sext(L) + sext(R), CODEC_W+1 bits. Mono = sum[CODEC_W : CODEC_W-SAMPLE_W+1].
//   This is an arithmetic mean truncated toward -inf; no rounding, no saturation needed.
//  Address wrap:
//   WRAP=0: writing address 2**ADDR_W-1 sets full=1 on the next cycle. FSM parks in ARMED.
//    full clears only on reset or on a start 1->0 transition.
//   WRAP=1: address rolls from 2**ADDR_W-1 to 0 and full stays 0.
//  start deasserted in any state: finish the current READ/WRITE pair (never split it),
//   then go to IDLE. Address is reset to 0 on the next start.
//  Tick arriving outside ARMED (busy, or parked by full):
//   WRAP=0 and full=1: the tick is not an overrun and is ignored.
//   Otherwise: overrun_cnt increments, saturating at 255.
//  Tick and timeout in the same cycle: the timeout is processed first; the new tick counts
//   as an overrun (overrun_cnt increments by 2 in total, saturating).
//  pause mid-operation: an in-flight WAIT_RDY/READ/WRITE completes; then hold in ARMED.
//  Reset mid-operation: the same-cycle write is suppressed (reset has priority over ram_wren).
// STRUCTURE
//  Shared package (audio_pkg): state enum capture_state_t (IDLE, ARMED, WAIT_RDY, READ, WRITE),
//   SAMPLE_W/CODEC_W constants, function mono_mix(L,R).
//  One sub-module: capture_addr_ctr (address counter + full flag + WRAP handling).
//  Everything else is flat in one always_ff plus a combinational next-state block.
// TESTING
//  1. L=24'h000100, R=24'h000300, read_ready=1, one tick -> read @tick+2;
//     ram_wren @tick+3 with ram_data=16'h0002 at address 0; sample_valid pulses once.
//  2. L=24'h800000, R=24'h800000 -> 16'h8000.
//     L=24'h7FFFFF, R=24'h800000 -> 16'hFFFF (floor of -0.5).
//  3. ADDR_W=4, WRAP=0, 20 ticks -> exactly 16 writes (addr 0..15); full=1 after the 16th;
//     overrun_cnt stays 0. The same bench with WRAP=1 -> 20 writes; addr 16 wraps to 0; full stays 0.
//  4. read_ready held 0 after a tick -> no read; after READY_TO+1 cycles overrun_cnt=1 and FSM in ARMED.
//     300 such events -> overrun_cnt saturates at 255.
//  5. pause=1 during 5 ticks -> no read/wren. start dropped between read and wren
//     -> that write completes, then IDLE; restart writes at address 0.
//  6. reset asserted in the WRITE cycle -> ram_wren=0 that cycle; all outputs 0 next cycle.

Source files
------------

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
//   Shared types and helpers for the record-side audio capture path.
//   - capture_state_t : capture FSM state encoding
//   - CODEC_W/SAMPLE_W: codec sample width and mono output width
//   - mono_mix()      : L/R to mono mix (arithmetic mean, floor rounding)
// -----------------------------------------------------------------------------
package audio_pkg;

  localparam int CODEC_W   = 24;
  localparam int SAMPLE_W  = 16;

  // The upper SAMPLE_W bits of the CODEC_W+1 bit sum hold the mean,
  // scaled from codec width down to sample width.
  localparam int MIX_SHIFT = CODEC_W - SAMPLE_W + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    WAIT_RDY = 3'd2,
    READ     = 3'd3,
    WRITE    = 3'd4
  } capture_state_t;

  // Sign-extended sum cannot overflow, so the arithmetic shift gives the
  // mean truncated toward -inf with no saturation required.
  function automatic logic [SAMPLE_W-1:0] mono_mix(
    input logic [CODEC_W-1:0] left,
    input logic [CODEC_W-1:0] right
  );
    logic signed [CODEC_W:0] sum;
    sum = $signed({left[CODEC_W-1], left}) + $signed({right[CODEC_W-1], right});
    return SAMPLE_W'(sum >>> MIX_SHIFT);
  endfunction

endpackage

// File: rtl/capture_addr_ctr.sv
// -----------------------------------------------------------------------------
// capture_addr_ctr
//   RAM write address counter with full flag for the capture path.
//   WRAP=0: counter stops at the last address and raises full.
//   WRAP=1: counter rolls over to 0; full never asserts.
// Ports
//   clk_i        : system clock
//   reset_i      : synchronous active-high reset
//   clear_i      : return address to 0 (new recording)
//   clear_full_i : drop the full flag (recording disabled)
//   incr_i       : a write was issued at addr_o this cycle
//   addr_o       : current write address
//   full_o       : last address written (WRAP=0 only)
// -----------------------------------------------------------------------------
module capture_addr_ctr #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned WRAP   = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              clear_full_i,
  input  logic              incr_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              full_o
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              full_q, full_d;

  always_comb begin
    addr_d = addr_q;
    full_d = full_q;
    if (clear_i) begin
      addr_d = '0;
    end else if (incr_i) begin
      if (addr_q != ADDR_LAST) begin
        addr_d = addr_q + 1'b1;
      end else if (WRAP != 0) begin
        addr_d = '0;
      end else begin
        full_d = 1'b1;
      end
    end
    // A start drop that coincides with the final write must still leave
    // the flag clear, otherwise the next recording would park forever.
    if (clear_full_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q <= '0;
      full_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      full_q <= full_d;
    end
  end

  assign addr_o = addr_q;
  assign full_o = full_q;

endmodule

// File: rtl/audio_capture_fsm.sv
// -----------------------------------------------------------------------------
// audio_capture_fsm
//   Pulls one L/R pair from the audio codec per sampling tick, mixes it to
//   signed 16-bit mono, writes it to message RAM and strobes the compressor.
// Parameters
//   ADDR_W   : RAM address width (depth 2**ADDR_W)
//   WRAP     : 0 stop when RAM full, 1 circular overwrite
//   READY_TO : clock cycles to wait for read_ready before dropping a sample
// Ports
//   clk_i, reset_i          : 50 MHz clock, synchronous active-high reset
//   sample_tick_i           : 1-cycle pulse per sample period
//   start_i, pause_i        : recording enable / hold levels
//   read_ready_i            : codec holds a fresh L/R pair
//   readdata_left_i/right_i : codec samples (signed, CODEC_W)
//   read_o                  : 1-cycle consume strobe to codec
//   ram_wraddress_o/data_o  : RAM write address / data
//   ram_wren_o              : RAM write enable
//   sample_out_o            : last mono sample, held
//   sample_valid_o          : 1-cycle strobe alongside ram_wren_o
//   full_o                  : RAM full (WRAP=0 only)
//   overrun_cnt_o           : saturating count of dropped samples
// -----------------------------------------------------------------------------
module audio_capture_fsm
  import audio_pkg::*;
#(
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned WRAP     = 0,
  parameter int unsigned READY_TO = 255
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                sample_tick_i,
  input  logic                start_i,
  input  logic                pause_i,
  input  logic                read_ready_i,
  input  logic [CODEC_W-1:0]  readdata_left_i,
  input  logic [CODEC_W-1:0]  readdata_right_i,
  output logic                read_o,
  output logic [ADDR_W-1:0]   ram_wraddress_o,
  output logic [SAMPLE_W-1:0] ram_data_o,
  output logic                ram_wren_o,
  output logic [SAMPLE_W-1:0] sample_out_o,
  output logic                sample_valid_o,
  output logic                full_o,
  output logic [7:0]          overrun_cnt_o
);

  localparam int unsigned     WAIT_W    = (READY_TO > 1) ? $clog2(READY_TO) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READY_TO - 1);

  capture_state_t      state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [7:0]          overrun_q, overrun_d;
  logic                start_q;

  logic                addr_clr;
  logic                addr_inc;
  logic                full_clr;
  logic                full;
  logic [ADDR_W-1:0]   addr;
  logic                timeout;
  logic                busy;
  logic                tick_ovr;
  logic [9:0]          ovr_sum;

  assign full_clr = start_q & ~start_i;

  capture_addr_ctr #(
    .ADDR_W (ADDR_W),
    .WRAP   (WRAP)
  ) u_addr_ctr (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clear_i      (addr_clr),
    .clear_full_i (full_clr),
    .incr_i       (addr_inc),
    .addr_o       (addr),
    .full_o       (full)
  );

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    sample_d       = sample_q;
    read_o         = 1'b0;
    ram_wren_o     = 1'b0;
    sample_valid_o = 1'b0;
    addr_clr       = 1'b0;
    addr_inc       = 1'b0;
    timeout        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = ARMED;
          addr_clr = 1'b1;
        end
      end

      ARMED: begin
        if (!start_i) begin
          state_d = IDLE;
        end else if (sample_tick_i && !pause_i && !full) begin
          state_d = WAIT_RDY;
          wait_d  = '0;
        end
      end

      // Nothing has been consumed from the codec yet, so a start drop
      // here can abandon the sample without splitting a read/write pair.
      WAIT_RDY: begin
        if (!start_i) begin
          state_d = IDLE;
        end else if (read_ready_i) begin
          state_d = READ;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ARMED;
          timeout = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      READ: begin
        read_o   = 1'b1;
        sample_d = mono_mix(readdata_left_i, readdata_right_i);
        state_d  = WRITE;
      end

      // Reset in this cycle must not leave a stray RAM write behind.
      WRITE: begin
        ram_wren_o     = ~reset_i;
        sample_valid_o = ~reset_i;
        addr_inc       = 1'b1;
        state_d        = start_i ? ARMED : IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A tick that lands while a sample is in flight is lost; a tick while
    // parked on a full RAM is expected and not counted.
    busy      = (state_q == WAIT_RDY) || (state_q == READ) || (state_q == WRITE);
    tick_ovr  = sample_tick_i && busy && !((WRAP == 0) && full);
    ovr_sum   = {2'b00, overrun_q} + {9'd0, timeout} + {9'd0, tick_ovr};
    overrun_d = (ovr_sum > 10'd255) ? 8'hFF : ovr_sum[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      sample_q  <= '0;
      overrun_q <= '0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      sample_q  <= sample_d;
      overrun_q <= overrun_d;
      start_q   <= start_i;
    end
  end

  assign ram_wraddress_o = addr;
  assign ram_data_o      = sample_q;
  assign sample_out_o    = sample_q;
  assign full_o          = full;
  assign overrun_cnt_o   = overrun_q;

endmodule
